// File: rtl/cmp_pkg.sv
// Shared types for the iterative comparator: MODE encoding, FSM states and
// the mapping from the registered magnitude relation to the selected result.
package cmp_pkg;

  typedef enum logic [2:0] {
    ModeUgt = 3'b000,
    ModeUge = 3'b001,
    ModeUlt = 3'b010,
    ModeUle = 3'b011,
    ModeEq  = 3'b100,
    ModeNe  = 3'b101,
    ModeSgt = 3'b110,
    ModeSlt = 3'b111
  } mode_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

  // Signed modes reuse gt/lt: when signed handling is built in, the sign-bit
  // inversion in the MSB chunk already turned the relation into a signed one.
  function automatic logic cmp_result(input mode_e mode, input logic gt, input logic eq,
                                      input logic lt);
    logic res;
    res = 1'b0;
    case (mode)
      ModeUgt, ModeSgt: res = gt;
      ModeUge:          res = gt | eq;
      ModeUlt, ModeSlt: res = lt;
      ModeUle:          res = lt | eq;
      ModeEq:           res = eq;
      ModeNe:           res = ~eq;
      default:          res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/cmp_chunk.sv
// Combinational unsigned compare of one chunk using the subtract/borrow-out
// method: the borrow of a-b gives lt, a non-zero difference without borrow gives gt.
module cmp_chunk #(
  parameter int unsigned Width = 4
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic             gt_o,
  output logic             lt_o
);

  logic [Width:0] diff;

  assign diff = {1'b0, a_i} - {1'b0, b_i};
  assign lt_o = diff[Width];
  assign gt_o = ~diff[Width] & (|diff[Width-1:0]);

endmodule

// File: rtl/cmp_iter.sv
// Iterative magnitude comparator: walks CHUNK-bit slices from the MSB down and
// stops at the first mismatch. Define CMP_ITER_SIGNED_EN to build signed MODE 110/111.
module cmp_iter
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic [2:0]       MODE,
  input  logic             VALID_IN,
  output logic             READY_OUT,
  output logic             VALID_OUT,
  input  logic             READY_IN,
  output logic             O,
  output logic             GT,
  output logic             EQ,
  output logic             LT
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IdxW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IdxW-1:0] IdxMsb = IdxW'(NCHUNK - 1);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             gt_q, gt_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;

  logic [CHUNK-1:0] chunk_a, chunk_b;
  logic             chunk_gt, chunk_lt;

  // Chunk selection; signed modes flip the operand sign bits in the MSB chunk.
  always_comb begin
    chunk_a = a_q[idx_q*CHUNK +: CHUNK];
    chunk_b = b_q[idx_q*CHUNK +: CHUNK];
`ifdef CMP_ITER_SIGNED_EN
    if ((idx_q == IdxMsb) && ((mode_q == ModeSgt) || (mode_q == ModeSlt))) begin
      chunk_a[CHUNK-1] = ~chunk_a[CHUNK-1];
      chunk_b[CHUNK-1] = ~chunk_b[CHUNK-1];
    end
`endif
  end

  cmp_chunk #(
    .Width(CHUNK)
  ) u_cmp_chunk (
    .a_i (chunk_a),
    .b_i (chunk_b),
    .gt_o(chunk_gt),
    .lt_o(chunk_lt)
  );

  // State register
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= StIdle;
      mode_q  <= ModeUgt;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    lt_d    = lt_q;

    unique case (state_q)
      StIdle: begin
        if (VALID_IN) begin
          a_d     = I0;
          b_d     = I1;
          mode_d  = mode_e'(MODE);
          idx_d   = IdxMsb;
          gt_d    = 1'b0;
          eq_d    = 1'b0;
          lt_d    = 1'b0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (chunk_gt) begin
          gt_d    = 1'b1;
          state_d = StDone;
        end else if (chunk_lt) begin
          lt_d    = 1'b1;
          state_d = StDone;
        end else if (idx_q == '0) begin
          eq_d    = 1'b1;
          state_d = StDone;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      StDone: begin
        if (READY_IN) begin
          // Relation flags only mean something while the result is presented.
          gt_d    = 1'b0;
          eq_d    = 1'b0;
          lt_d    = 1'b0;
          idx_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    READY_OUT = (state_q == StIdle);
    VALID_OUT = (state_q == StDone);
    O         = (state_q == StDone) && cmp_result(mode_q, gt_q, eq_q, lt_q);
    GT        = gt_q;
    EQ        = eq_q;
    LT        = lt_q;
  end

endmodule

// File: tb/tb_cmp_iter.sv
// Scoreboard bench for cmp_iter (WIDTH=16, CHUNK=4): the driver queues expected
// results, a monitor checks them when VALID_OUT rises.
module tb_cmp_iter;

  logic        CLK = 1'b0;
  logic        RESETN = 1'b0;
  logic [15:0] I0 = '0;
  logic [15:0] I1 = '0;
  logic [2:0]  MODE = '0;
  logic        VALID_IN = 1'b0;
  logic        READY_IN = 1'b0;
  logic        READY_OUT, VALID_OUT, O, GT, EQ, LT;

  cmp_iter #(
    .WIDTH(16),
    .CHUNK(4)
  ) dut (
    .CLK      (CLK),
    .RESETN   (RESETN),
    .I0       (I0),
    .I1       (I1),
    .MODE     (MODE),
    .VALID_IN (VALID_IN),
    .READY_OUT(READY_OUT),
    .VALID_OUT(VALID_OUT),
    .READY_IN (READY_IN),
    .O        (O),
    .GT       (GT),
    .EQ       (EQ),
    .LT       (LT)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic  o, gt, eq, lt;
    int    cyc;
    string name;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: one check per DONE period, on its first visible cycle.
  logic in_done = 1'b0;
  always @(negedge CLK) begin
    exp_t e;
    if (!RESETN) begin
      in_done = 1'b0;
    end else if (VALID_OUT && !in_done) begin
      in_done = 1'b1;
      if (sb.size() == 0) begin
        chk("unexpected_valid_out", 32'(VALID_OUT), 32'd0);
      end else begin
        e = sb.pop_front();
        chk({e.name, ".O"}, 32'(O), 32'(e.o));
        chk({e.name, ".GT"}, 32'(GT), 32'(e.gt));
        chk({e.name, ".EQ"}, 32'(EQ), 32'(e.eq));
        chk({e.name, ".LT"}, 32'(LT), 32'(e.lt));
        chk({e.name, ".latency_cycle"}, 32'(cyc), 32'(e.cyc));
      end
    end else if (!VALID_OUT) begin
      in_done = 1'b0;
    end
  end

  task automatic run_req(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] mode, input logic eo, input logic egt,
                         input logic eeq, input logic elt, input int lat, input int hold);
    exp_t e;
    @(negedge CLK);
    I0 = a;
    I1 = b;
    MODE = mode;
    VALID_IN = 1'b1;
    e.o = eo;
    e.gt = egt;
    e.eq = eeq;
    e.lt = elt;
    e.cyc = cyc + 1 + lat;
    e.name = name;
    sb.push_back(e);
    @(negedge CLK);
    // Garbage with VALID_IN held high while busy must be ignored.
    I0 = ~a;
    I1 = a;
    MODE = ~mode;
    for (int i = 0; i < 20 && !VALID_OUT; i++) @(negedge CLK);
    VALID_IN = 1'b0;
    if (!VALID_OUT) begin
      chk({name, ".timeout"}, 32'(VALID_OUT), 32'd1);
      return;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      chk({name, ".hold_valid"}, 32'(VALID_OUT), 32'd1);
      chk({name, ".hold_O"}, 32'(O), 32'(eo));
      chk({name, ".hold_ready_out"}, 32'(READY_OUT), 32'd0);
    end
    READY_IN = 1'b1;
    @(negedge CLK);
    READY_IN = 1'b0;
    chk({name, ".release_ready_out"}, 32'(READY_OUT), 32'd1);
    chk({name, ".release_valid_out"}, 32'(VALID_OUT), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic sgt_o, sgt_gt, sgt_lt, slt_o, slt_gt, slt_lt;
`ifdef CMP_ITER_SIGNED_EN
    sgt_o = 1'b0; sgt_gt = 1'b0; sgt_lt = 1'b1;  // -32768 > 1 is false
    slt_o = 1'b1; slt_gt = 1'b0; slt_lt = 1'b1;  // -1 < 1
`else
    sgt_o = 1'b1; sgt_gt = 1'b1; sgt_lt = 1'b0;  // falls back to UGT
    slt_o = 1'b0; slt_gt = 1'b1; slt_lt = 1'b0;  // falls back to ULT, 0xFFFF > 1
`endif

    repeat (2) @(negedge CLK);
    chk("reset.ready_out", 32'(READY_OUT), 32'd1);
    chk("reset.valid_out", 32'(VALID_OUT), 32'd0);
    chk("reset.O", 32'(O), 32'd0);
    chk("reset.GT_EQ_LT", {29'd0, GT, EQ, LT}, 32'd0);
    RESETN = 1'b1;
    @(negedge CLK);

    run_req("ugt_8000_0001", 16'h8000, 16'h0001, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0);
    run_req("sgt_8000_0001", 16'h8000, 16'h0001, 3'b110, sgt_o, sgt_gt, 1'b0, sgt_lt, 1, 0);
    run_req("ule_1234_1235", 16'h1234, 16'h1235, 3'b011, 1'b1, 1'b0, 1'b0, 1'b1, 4, 0);
    run_req("eq_beef",       16'hBEEF, 16'hBEEF, 3'b100, 1'b1, 1'b0, 1'b1, 1'b0, 4, 0);
    run_req("ne_beef",       16'hBEEF, 16'hBEEF, 3'b101, 1'b0, 1'b0, 1'b1, 1'b0, 4, 0);
    run_req("uge_00f0_hold", 16'h00F0, 16'h00E0, 3'b001, 1'b1, 1'b1, 1'b0, 1'b0, 3, 5);
    run_req("ult_0005_0003", 16'h0005, 16'h0003, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 4, 0);
    run_req("slt_ffff_0001", 16'hFFFF, 16'h0001, 3'b111, slt_o, slt_gt, 1'b0, slt_lt, 1, 0);
    run_req("sgt_7000_6fff", 16'h7000, 16'h6FFF, 3'b110, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0);

    // Reset in the second RUN cycle of 0x1111 vs 0x1112.
    @(negedge CLK);
    I0 = 16'h1111;
    I1 = 16'h1112;
    MODE = 3'b010;
    VALID_IN = 1'b1;
    @(negedge CLK);
    VALID_IN = 1'b0;
    @(negedge CLK);
    RESETN = 1'b0;
    #1;
    chk("midrun_reset.ready_out", 32'(READY_OUT), 32'd1);
    chk("midrun_reset.valid_out", 32'(VALID_OUT), 32'd0);
    chk("midrun_reset.O", 32'(O), 32'd0);
    chk("midrun_reset.GT_EQ_LT", {29'd0, GT, EQ, LT}, 32'd0);
    @(negedge CLK);
    RESETN = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      chk("post_reset.no_valid", 32'(VALID_OUT), 32'd0);
    end
    run_req("ult_1111_1112", 16'h1111, 16'h1112, 3'b010, 1'b1, 1'b0, 1'b0, 1'b1, 4, 0);

    repeat (3) @(negedge CLK);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
